// File: rtl/booth_mult_if.sv
// Handshake and operand/product bundle between the ALU control FSM and the Booth MUL unit.
interface booth_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     mc;
  logic [WIDTH-1:0]     mp;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   prod;

  modport master (
    output start, signed_mode, mc, mp,
    input  ready, busy, done, prod
  );

  modport slave (
    input  start, signed_mode, mc, mp,
    output ready, busy, done, prod
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock on (WIDTH+1)-bit
// operands, so the same datapath handles signed and unsigned inputs.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  booth_mult_if.slave mul_io
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     q_q, q_d;
  logic               q1_q, q1_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      count_q <= count_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    count_d = count_q;
    prod_d  = prod_q;
    sum     = a_q;

    unique case (state_q)
      StIdle: begin
        if (mul_io.start) begin
          // Extra top bit turns unsigned operands into non-negative signed ones.
          m_d     = {mul_io.signed_mode & mul_io.mc[WIDTH-1], mul_io.mc};
          q_d     = {mul_io.signed_mode & mul_io.mp[WIDTH-1], mul_io.mp};
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        unique case ({q_q[0], q1_q})
          2'b01:   sum = a_q + m_q;
          2'b10:   sum = a_q - m_q;
          default: sum = a_q;
        endcase
        a_d  = {sum[WIDTH], sum[WIDTH:1]};
        q_d  = {sum[0], q_q[WIDTH:1]};
        q1_d = q_q[0];
        if (count_q == CntW'(WIDTH)) begin
          prod_d  = {a_d[WIDTH-2:0], q_d};
          state_d = StDone;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mul_io.ready = (state_q == StIdle);
  assign mul_io.busy  = (state_q == StRun);
  assign mul_io.done  = (state_q == StDone);
  assign mul_io.prod  = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH = 8, 4 and 16.
module tb_booth_mult_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  booth_mult_if #(.WIDTH(8))  m8 ();
  booth_mult_if #(.WIDTH(4))  m4 ();
  booth_mult_if #(.WIDTH(16)) m16 ();

  booth_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .mul_io(m8));
  booth_mult_seq #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .mul_io(m4));
  booth_mult_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .mul_io(m16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sm;
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] model(input bit sm, input int w, input logic [31:0] a,
                                        input logic [31:0] b);
    longint     x;
    longint     y;
    logic [63:0] mask;
    x = longint'(a);
    y = longint'(b);
    if (sm && a[w-1]) x = x - (longint'(1) << w);
    if (sm && b[w-1]) y = y - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(x * y) & mask;
  endfunction

  task automatic run8(input bit sm, input logic [7:0] a, input logic [7:0] b, input bit inject,
                      output logic [15:0] p, output int lat, output int nbusy, output bit stable);
    logic [15:0] p0;
    @(negedge clk);
    p0 = m8.prod;
    stable = 1'b1;
    m8.start = 1'b1;
    m8.signed_mode = sm;
    m8.mc = a;
    m8.mp = b;
    @(negedge clk);
    m8.start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!m8.done && lat < 40) begin
      if (m8.busy) nbusy++;
      if (m8.prod !== p0) stable = 1'b0;
      if (inject && lat == 3) begin
        m8.start = 1'b1;
        m8.signed_mode = ~sm;
        m8.mc = ~a;
        m8.mp = b + 8'd3;
      end else begin
        m8.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    m8.start = 1'b0;
    p = m8.prod;
  endtask

  task automatic run4(input bit sm, input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] p, output int lat, output int nbusy);
    @(negedge clk);
    m4.start = 1'b1;
    m4.signed_mode = sm;
    m4.mc = a;
    m4.mp = b;
    @(negedge clk);
    m4.start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!m4.done && lat < 40) begin
      if (m4.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    p = m4.prod;
  endtask

  task automatic run16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output int lat);
    @(negedge clk);
    m16.start = 1'b1;
    m16.signed_mode = sm;
    m16.mc = a;
    m16.mp = b;
    @(negedge clk);
    m16.start = 1'b0;
    lat = 1;
    while (!m16.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    p = m16.prod;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [15:0] p8;
    logic [15:0] p8_first;
    logic [7:0]  p4;
    logic [31:0] p16;
    int          lat;
    int          nbusy;
    int          ndone;
    bit          stable;
    bit          sm;
    logic [7:0]  ra;
    logic [7:0]  rb;

    n_checks = 0;
    n_fails  = 0;

    vecs[0] = '{sm: 1'b0, mc: 8'hFF, mp: 8'hFF, exp: 16'hFE01};
    vecs[1] = '{sm: 1'b1, mc: 8'h80, mp: 8'h80, exp: 16'h4000};
    vecs[2] = '{sm: 1'b1, mc: 8'hFF, mp: 8'h02, exp: 16'hFFFE};
    vecs[3] = '{sm: 1'b0, mc: 8'hFF, mp: 8'h02, exp: 16'h01FE};
    vecs[4] = '{sm: 1'b1, mc: 8'h00, mp: 8'h7F, exp: 16'h0000};
    vecs[5] = '{sm: 1'b1, mc: 8'h7F, mp: 8'h81, exp: 16'hC0FF};

    m8.start = 1'b0;  m8.signed_mode = 1'b0;  m8.mc = '0;  m8.mp = '0;
    m4.start = 1'b0;  m4.signed_mode = 1'b0;  m4.mc = '0;  m4.mp = '0;
    m16.start = 1'b0; m16.signed_mode = 1'b0; m16.mc = '0; m16.mp = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(m8.ready), 64'd1);
    check("reset_busy",  64'(m8.busy),  64'd0);
    check("reset_done",  64'(m8.done),  64'd0);
    check("reset_prod",  64'(m8.prod),  64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run8(vecs[i].sm, vecs[i].mc, vecs[i].mp, 1'b0, p8, lat, nbusy, stable);
      check($sformatf("vec%0d_prod", i), 64'(p8), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd10);
      check($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'd9);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), 64'(m8.done), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      sm = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(sm, ra, rb, 1'b0, p8, lat, nbusy, stable);
      check($sformatf("rand%0d_sm%0d_%0h_x_%0h", i, sm, ra, rb), 64'(p8), model(sm, 8, 32'(ra), 32'(rb)));
    end

    // Start pulse mid-run with other operands must be ignored.
    run8(1'b1, 8'h93, 8'h5A, 1'b1, p8, lat, nbusy, stable);
    check("ignore_start_prod", 64'(p8), model(1'b1, 8, 32'h93, 32'h5A));
    check("ignore_start_latency", 64'(lat), 64'd10);
    p8_first = p8;

    // Back-to-back: next start in the cycle after done; prod held until new done.
    run8(1'b0, 8'hC3, 8'h3C, 1'b0, p8, lat, nbusy, stable);
    check("b2b_prod", 64'(p8), model(1'b0, 8, 32'hC3, 32'h3C));
    check("b2b_latency", 64'(lat), 64'd10);
    check("b2b_prod_stable", 64'(stable), 64'd1);
    if (p8_first == p8) check("b2b_prod_changed", 64'(p8), 64'(p8) + 64'd1);

    // Reset at RUN step 4 aborts the operation.
    @(negedge clk);
    m8.start = 1'b1; m8.signed_mode = 1'b0; m8.mc = 8'hAB; m8.mp = 8'hCD;
    @(negedge clk);
    m8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(m8.ready), 64'd1);
    check("midrst_busy",  64'(m8.busy),  64'd0);
    check("midrst_done",  64'(m8.done),  64'd0);
    check("midrst_prod",  64'(m8.prod),  64'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (m8.done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run8(1'b1, 8'hAB, 8'hCD, 1'b0, p8, lat, nbusy, stable);
    check("after_rst_prod", 64'(p8), model(1'b1, 8, 32'hAB, 32'hCD));
    check("after_rst_latency", 64'(lat), 64'd10);

    run4(1'b1, 4'h8, 4'h7, p4, lat, nbusy);
    check("w4_signed_prod", 64'(p4), 64'hC8);
    check("w4_latency", 64'(lat), 64'd6);
    check("w4_busy_cycles", 64'(nbusy), 64'd5);
    for (int i = 0; i < 16; i++) begin
      sm = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      run4(sm, ra[3:0], rb[3:0], p4, lat, nbusy);
      check($sformatf("w4_rand%0d", i), 64'(p4), model(sm, 4, 32'(ra), 32'(rb)));
    end

    run16(1'b0, 16'hFFFF, 16'hFFFF, p16, lat);
    check("w16_unsigned_prod", 64'(p16), 64'hFFFE0001);
    check("w16_latency", 64'(lat), 64'd18);
    run16(1'b1, 16'h8000, 16'h8000, p16, lat);
    check("w16_signed_extreme", 64'(p16), 64'h40000000);
    run16(1'b1, 16'h1234, 16'hF00D, p16, lat);
    check("w16_signed_mixed", 64'(p16), model(1'b1, 16, 32'h1234, 32'hF00D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
